// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with a small show-ahead FIFO and sticky framing/overrun flags.
// Bit timing comes from a runtime divider latched at each start-bit detection.
module uart_rx_fifo #(
    parameter int unsigned DIVW  = 12,
    parameter int unsigned LOG2D = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rxd,
    input  logic [DIVW-1:0] divider,
    input  logic            rd,
    input  logic            clr,
    output logic [7:0]      dout,
    output logic            dv,
    output logic            busy,
    output logic            ferr,
    output logic            ovf
);

    localparam int unsigned Depth = 2 ** LOG2D;
    localparam logic [DIVW-1:0] CntOne = DIVW'(1);
    localparam logic [LOG2D:0] PtrOne = (LOG2D + 1)'(1);
    localparam logic [LOG2D:0] PtrMsb = {1'b1, {LOG2D{1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHi
    } state_e;

    logic            sync1_q, rxs_q, rxs_prev_q;
    state_e          state_q;
    logic [DIVW-1:0] cnt_q, div_q;
    logic [2:0]      bit_q;
    logic [7:0]      sh_q;
    logic            busy_q;
    logic [7:0]      mem_q [Depth];
    logic [LOG2D:0]  wptr_q, rptr_q;
    logic            ferr_q, ovf_q;

    logic fall, expire, push, frame_err;
    logic empty, full, pop, wr_en, ovf_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= rxd;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    assign fall      = rxs_prev_q & ~rxs_q;
    assign expire    = (cnt_q == '0);
    assign push      = (state_q == StStop) && expire && rxs_q;
    assign frame_err = (state_q == StStop) && expire && !rxs_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fall) begin
                        div_q   <= divider;
                        cnt_q   <= divider >> 1;
                        state_q <= StStart;
                        busy_q  <= 1'b1;
                    end
                end
                StStart: begin
                    if (!expire) begin
                        cnt_q <= cnt_q - CntOne;
                    end else if (rxs_q) begin
                        // Line went back high before mid-start: treat as a glitch.
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= div_q;
                        bit_q   <= '0;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (!expire) begin
                        cnt_q <= cnt_q - CntOne;
                    end else begin
                        cnt_q <= div_q;
                        sh_q  <= {rxs_q, sh_q[7:1]};
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end
                end
                StStop: begin
                    if (!expire) begin
                        cnt_q <= cnt_q - CntOne;
                    end else begin
                        cnt_q <= div_q;
                        if (rxs_q) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= StWaitHi;
                        end
                    end
                end
                StWaitHi: begin
                    // A held-low line (break) must not restart decoding until it idles.
                    if (rxs_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign empty   = (wptr_q == rptr_q);
    assign full    = ((wptr_q ^ rptr_q) == PtrMsb);
    assign pop     = rd & ~empty;
    assign wr_en   = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q[LOG2D-1:0]] <= sh_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr_q <= wptr_q + PtrOne;
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrOne;
            end
            ferr_q <= frame_err | (ferr_q & ~clr);
            ovf_q  <= ovf_set | (ovf_q & ~clr);
        end
    end

    assign dout = empty ? 8'h00 : mem_q[rptr_q[LOG2D-1:0]];
    assign dv   = ~empty;
    assign busy = busy_q;
    assign ferr = ferr_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner sequences,
// and randomized frames/pops checked against a queue-based model of the receiver.
module tb_uart_rx_fifo;

    localparam int unsigned DIVW = 12;

    logic            clk = 1'b0;
    logic            reset, rxd, rd, clr;
    logic [DIVW-1:0] divider;
    logic [7:0]      dout;
    logic            dv, busy, ferr, ovf;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic       m_ferr, m_ovf;

    typedef struct {
        int         div;
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_dout;
        logic       exp_dv;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];

    uart_rx_fifo #(.DIVW(DIVW), .LOG2D(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .rxd    (rxd),
        .divider(divider),
        .rd     (rd),
        .clr    (clr),
        .dout   (dout),
        .dv     (dv),
        .busy   (busy),
        .ferr   (ferr),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame; the stop level is held for stop_bits bit times, then the line idles.
    task automatic send_frame(input logic [7:0] b, input int d, input int stop_bits,
                              input logic stop_lvl);
        divider = d[DIVW-1:0];
        rxd = 1'b0;
        cyc(d + 1);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cyc(d + 1);
        end
        rxd = stop_lvl;
        cyc(stop_bits * (d + 1));
        rxd = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            cyc(1);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic pop_pulse();
        rd = 1'b1;
        cyc(1);
        rd = 1'b0;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        chk(name, dout, exp);
        pop_pulse();
    endtask

    task automatic m_frame(input logic [7:0] b, input logic ok);
        if (!ok) m_ferr = 1'b1;
        else if (mq.size() == 4) m_ovf = 1'b1;
        else mq.push_back(b);
    endtask

    task automatic m_check(input string tag);
        chk({tag, "_dv"}, dv, (mq.size() != 0));
        chk({tag, "_dout"}, dout, (mq.size() != 0) ? mq[0] : 8'h00);
        chk({tag, "_ferr"}, ferr, m_ferr);
        chk({tag, "_ovf"}, ovf, m_ovf);
    endtask

    initial begin
        vecs[0] = '{3,  8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{4,  8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{7,  8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[3] = '{12, 8'h81, 1'b1, 8'h81, 1'b1, 1'b0};
        vecs[4] = '{5,  8'h5A, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{9,  8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0};

        rxd = 1'b1; rd = 1'b0; clr = 1'b0; divider = 12'd155; reset = 1'b1;
        cyc(3);
        chk("rst_dout", dout, 8'h00);
        chk("rst_dv", dv, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_ovf", ovf, 0);
        reset = 1'b0;
        cyc(2);

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].div, 1, vecs[i].stop);
            cyc(vecs[i].div + 2);
            wait_idle(50);
            chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
            chk($sformatf("vec%0d_dv", i), dv, vecs[i].exp_dv);
            chk($sformatf("vec%0d_ferr", i), ferr, vecs[i].exp_ferr);
            pop_pulse();
            clr_pulse();
        end

        // 0x41 at divider 155: stop sample lands 1485 edges after the rxd fall.
        fork
            send_frame(8'h41, 155, 1, 1'b1);
            begin
                repeat (1484) @(posedge clk);
                #1 chk("t1_dv_before_stop", dv, 0);
                @(posedge clk);
                #1;
                chk("t1_dv", dv, 1);
                chk("t1_dout", dout, 8'h41);
                chk("t1_ferr", ferr, 0);
                chk("t1_ovf", ovf, 0);
            end
        join
        wait_idle(50);
        pop_pulse();
        chk("t1_dv_after_pop", dv, 0);

        // 300 ns glitch
        rxd = 1'b0;
        cyc(6);
        chk("glitch_busy", busy, 1);
        cyc(24);
        rxd = 1'b1;
        cyc(150);
        chk("glitch_idle", busy, 0);
        chk("glitch_dv", dv, 0);
        chk("glitch_ferr", ferr, 0);

        // Break: stop bit held low for three bit times
        fork
            send_frame(8'h55, 155, 3, 1'b0);
            begin
                repeat (1490) @(posedge clk);
                #1;
                chk("brk_ferr", ferr, 1);
                chk("brk_busy", busy, 1);
                chk("brk_dv", dv, 0);
                repeat (300) @(posedge clk);
                #1 chk("brk_waithi", busy, 1);
            end
        join
        cyc(5);
        chk("brk_released", busy, 0);
        send_frame(8'h0F, 155, 1, 1'b1);
        cyc(3);
        chk("brk_next_dout", dout, 8'h0F);
        chk("brk_next_dv", dv, 1);
        chk("brk_ferr_sticky", ferr, 1);
        pop_pulse();
        clr_pulse();
        chk("brk_ferr_clr", ferr, 0);

        // Five back-to-back frames into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 155, 1, 1'b1);
        cyc(3);
        chk("ovf_set", ovf, 1);
        chk("ovf_dv", dv, 1);
        for (int i = 1; i <= 4; i++) pop_expect($sformatf("ovf_pop%0d", i), 8'(i));
        chk("ovf_empty_dv", dv, 0);
        chk("ovf_empty_dout", dout, 8'h00);
        clr_pulse();
        chk("ovf_clr", ovf, 0);

        // Full FIFO with a pop in the same cycle as the fifth push
        for (int i = 1; i <= 4; i++) send_frame(8'h10 + 8'(i), 7, 1, 1'b1);
        fork
            send_frame(8'h15, 7, 1, 1'b1);
            begin
                repeat (78) @(posedge clk);
                #1 rd = 1'b1;
                @(posedge clk);
                #1 rd = 1'b0;
            end
        join
        cyc(2);
        chk("fullpop_ovf", ovf, 0);
        for (int i = 2; i <= 5; i++) pop_expect($sformatf("fullpop%0d", i), 8'h10 + 8'(i));
        chk("fullpop_empty", dv, 0);

        // clr coinciding with a framing error: set wins
        chk("clrset_pre", ferr, 0);
        fork
            send_frame(8'h33, 7, 1, 1'b0);
            begin
                repeat (78) @(posedge clk);
                #1 clr = 1'b1;
                @(posedge clk);
                #1 clr = 1'b0;
                chk("clrset_ferr", ferr, 1);
            end
        join
        wait_idle(50);
        chk("clrset_hold", ferr, 1);
        clr_pulse();
        chk("clrset_cleared", ferr, 0);

        // Reset during data bit 4 with flags and FIFO populated
        send_frame(8'h77, 7, 1, 1'b0);
        wait_idle(50);
        for (int i = 0; i < 5; i++) send_frame(8'h60 + 8'(i), 7, 1, 1'b1);
        cyc(3);
        chk("rstmid_pre_ferr", ferr, 1);
        chk("rstmid_pre_ovf", ovf, 1);
        chk("rstmid_pre_dv", dv, 1);
        fork
            send_frame(8'hAA, 7, 1, 1'b1);
            begin
                repeat (44) @(posedge clk);
                #1 chk("rstmid_pre_busy", busy, 1);
                reset = 1'b1;
                #1;
                chk("rstmid_dout", dout, 8'h00);
                chk("rstmid_dv", dv, 0);
                chk("rstmid_busy", busy, 0);
                chk("rstmid_ferr", ferr, 0);
                chk("rstmid_ovf", ovf, 0);
            end
        join
        cyc(2);
        reset = 1'b0;
        cyc(3);
        chk("rstmid_idle", busy, 0);
        send_frame(8'hA5, 7, 1, 1'b1);
        cyc(3);
        chk("rstmid_a5_dout", dout, 8'hA5);
        chk("rstmid_a5_dv", dv, 1);
        pop_pulse();

        // Randomized frames, pops and clears against the queue model
        mq.delete();
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
        for (int it = 0; it < 40; it++) begin
            int         d;
            int         kind;
            logic [7:0] b;
            d    = $urandom_range(3, 12);
            b    = 8'($urandom);
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                send_frame(b, d, 1, 1'b0);
                m_frame(b, 1'b0);
            end else if (kind < 4) begin
                pop_pulse();
                if (mq.size() != 0) void'(mq.pop_front());
            end else if (kind == 4) begin
                clr_pulse();
                m_ferr = 1'b0;
                m_ovf  = 1'b0;
            end else begin
                send_frame(b, d, 1, 1'b1);
                m_frame(b, 1'b1);
            end
            cyc(3);
            wait_idle(40);
            m_check($sformatf("rnd%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end of the laRVa_DC SoC. It sits directly downstream of the `rxd` pin of `SYSTEM`. It synchronises and deserialises 8N1 asynchronous frames and buffers the received bytes in a small FIFO. The CPU peripheral bus drains the FIFO through a show-ahead read port and sees sticky framing and overrun flags.

## Interface
Parameters:
- `DIVW`, default 12: width of the bit-period divider input.
- `LOG2D`, default 2: log2 of the FIFO depth, so the default depth is 4 entries.

Ports:
- `clk`  input  1: system clock; all logic is on the rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `rxd`  input  1: raw serial line; idles high.
- `divider`  input  DIVW: bit period in clock cycles, minus 1. Sampled at each start-bit detection.
- `rd`  input  1: pop strobe, one cycle wide.
- `clr`  input  1: clears `ferr` and `ovf`.
- `dout`  output  8: byte at the FIFO head; 8'h00 when the FIFO is empty.
- `dv`  output  1: FIFO not empty.
- `busy`  output  1: a frame is in progress (state is not IDLE).
- `ferr`  output  1: sticky framing error.
- `ovf`  output  1: sticky overrun.

## Operation
- `rxd` passes through a 2-flop synchroniser (`rxs`), reset to 1. The edge detector compares `rxs` with its previous value, also reset to 1.
- Bit-timer counter `cnt` (DIVW bits) counts down and "expires" when it reaches 0. At each expiry it reloads to `div_l`, the value of `divider` latched at start detection.
- State machine states: IDLE, START, DATA, STOP, WAITHI.
  - IDLE: on a falling edge of `rxs`, latch `div_l = divider`, load `cnt = divider >> 1`, and go to START.
  - START: on expiry, if `rxs` is 1 the start bit was a glitch; return to IDLE with no flags set. Otherwise reload `cnt` and go to DATA with bit index 0.
  - DATA: on each expiry, shift `rxs` into `sh[7]` and shift `sh` right, so data is received LSB first. After the 8th bit go to STOP.
  - STOP: on expiry, if `rxs` is 1, push `sh` and go to IDLE. If `rxs` is 0, set `ferr`, do not push, and go to WAITHI.
  - WAITHI: remain until `rxs` is 1, then go to IDLE. This prevents a break condition from being decoded as a stream of frames.
- FIFO: 2^LOG2D entries, with LOG2D+1-bit read and write pointers that wrap naturally. Full means the pointers differ only in their MSB; empty means the pointers are equal.
  - `rd` while empty: ignored; pointers unchanged.
  - Push while full with no pop in the same cycle: byte dropped, `ovf` set, pointers unchanged.
  - Push and pop in the same cycle: both take effect. A simultaneous pop and push while full is not an overrun. A simultaneous pop and push while empty is not allowed, because the pop is ignored when empty.
- Flags:
  - `clr` clears `ferr` and `ovf` on the next edge.
  - If `clr` coincides with a new error event, the set wins.
  - The flags have no effect on reception.
- `divider` must be at least 3. Changing `divider` mid-frame has no effect on the frame in progress.

## Timing
- Reset values:
  - state IDLE, `cnt` 0, pointers 0, `sh` 0.
  - `dout` 8'h00, `dv` 0, `busy` 0, `ferr` 0, `ovf` 0.
- Synchroniser latency: 2 cycles from an `rxd` transition to `rxs`.
- Sample instants, measured from the cycle in which the falling edge of `rxs` is seen (cycle 0):
  - start bit: cycle `(divider>>1)+1`.
  - data bit k (k = 0 to 7): start sample + `(k+1)*(divider+1)`.
  - stop bit: start sample + `9*(divider+1)`.
- Push latency: `dv` rises and `dout` is valid 1 cycle after the stop-bit sample edge.
- Pop latency: after an `rd` edge, `dout` shows the next entry in the same cycle that the pointer updates. `dv` drops in that cycle if the FIFO became empty.
- `busy` rises 1 cycle after edge detection. It falls on the cycle the state returns to IDLE.
- Reset asserted mid-frame: everything returns to the reset values immediately (asynchronously). A partial byte is discarded. After reset is released, reception waits for the next falling edge.

## Test plan
- 100 MHz clock, `divider` = 155 (1560 ns bit time). Send 0x41 as 0, 1,0,0,0,0,0,1,0, 1. Required: `dv` = 1 and `dout` = 0x41 one cycle after the stop sample; `ferr` = 0 and `ovf` = 0.
- With the same setup, a 300 ns low glitch on `rxd`. Required: `busy` pulses, then returns to IDLE; `dv` = 0; `ferr` = 0.
- Frame 0x55 with the stop bit held at 0 for 3 bit times. Required: `ferr` = 1, no push, state stays in WAITHI until `rxd` goes high. A following frame 0x0F is then received correctly.
- Five back-to-back frames 0x01 to 0x05 with LOG2D = 2 and no reads. Required: `ovf` = 1; four `rd` pulses return 0x01, 0x02, 0x03, 0x04; then `dv` = 0 and `dout` = 0x00.
- FIFO full, with `rd` asserted in the same cycle as the push of a fifth byte. Required: `ovf` stays 0; after that cycle the FIFO still holds 4 entries. `clr` pulsed in the same cycle as a framing error leaves `ferr` = 1.
- Assert `reset` in the middle of data bit 4. Required: all outputs return to their reset values immediately. After release, the next frame 0xA5 is received intact.
